// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALU op encodings, datapath select codes and control FSM states
// shared by the MIPS multicycle control slice.
package mips_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [2:0] ALUOP_ADD  = 3'b000;
   localparam logic [2:0] ALUOP_FUNC = 3'b001;
   localparam logic [2:0] ALUOP_SUB  = 3'b010;

   localparam logic [1:0] SRCB_REGB   = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_RESET,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_ALUWB,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_BRANCH,
      S_ADDIEX,
      S_ADDIWB,
      S_JUMP,
      S_ILLEGAL
   } state_t;

   // First state after DECODE for a given opcode; unknown opcodes trap.
   function automatic state_t decode_op(input logic [5:0] op);
      return op == OP_R                  ? S_EXEC   :
             op == OP_LW || op == OP_SW  ? S_MEMADR :
             op == OP_BEQ                ? S_BRANCH :
             op == OP_ADDI               ? S_ADDIEX :
             op == OP_J                  ? S_JUMP   : S_ILLEGAL;
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/handshake inputs and datapath strobes between
// the multicycle controller (master) and the datapath (slave).
interface multicycle_control_if #(parameter int CNT_W = 32);

   logic [5:0]       Op;
   logic             Zero;
   logic             MemReady;
   logic             PcWrite;
   logic             PcWriteCond;
   logic             IorD;
   logic             MemRead;
   logic             MemWrite;
   logic             IrWrite;
   logic             MemToReg;
   logic             RegDst;
   logic             RegWrite;
   logic             AluSrcA;
   logic [1:0]       AluSrcB;
   logic [1:0]       PcSrc;
   logic [2:0]       Aop;
   logic             Illegal;
   logic [CNT_W-1:0] InstrCount;

   modport master (
      input  Op, Zero, MemReady,
      output PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite, MemToReg,
             RegDst, RegWrite, AluSrcA, AluSrcB, PcSrc, Aop, Illegal, InstrCount
   );

   modport slave (
      output Op, Zero, MemReady,
      input  PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite, MemToReg,
             RegDst, RegWrite, AluSrcA, AluSrcB, PcSrc, Aop, Illegal, InstrCount
   );

endinterface

// File: rtl/retire_counter.sv
// retire_counter: wrapping enable counter of retired instructions, async active-low clear.
module retire_counter #(parameter int CNT_W = 32) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n)
         count <= '0;
      else if (en)
         count <= count + CNT_W'(1);

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS datapath; sequences
// fetch/decode/execute/memory/writeback and decodes every datapath strobe from state.
module multicycle_control
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic                  Clk,
   input logic                  Rst_n,
   multicycle_control_if.master bus
);

   state_t state, state_next;
   logic   retire;
   logic   unused_zero;

   // Zero only qualifies PcWriteCond inside the datapath.
   assign unused_zero = bus.Zero;

   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n)
         state <= S_RESET;
      else
         state <= state_next;

   always_comb begin
      state_next      = state;
      retire          = 1'b0;
      bus.PcWrite     = 1'b0;
      bus.PcWriteCond = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IrWrite     = 1'b0;
      bus.MemToReg    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.AluSrcA     = 1'b0;
      bus.AluSrcB     = SRCB_REGB;
      bus.PcSrc       = PCSRC_ALU;
      bus.Aop         = ALUOP_ADD;
      bus.Illegal     = 1'b0;
      case (state)
         S_RESET:
            state_next = S_FETCH;
         S_FETCH: begin
            bus.MemRead = 1'b1;
            bus.AluSrcB = SRCB_FOUR;
            bus.IrWrite = bus.MemReady;
            bus.PcWrite = bus.MemReady;
            state_next  = bus.MemReady ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            bus.AluSrcB = SRCB_IMM_SH;
            state_next  = decode_op(bus.Op);
         end
         S_EXEC: begin
            bus.AluSrcA = 1'b1;
            bus.Aop     = ALUOP_FUNC;
            state_next  = S_ALUWB;
         end
         S_ALUWB: begin
            bus.RegDst   = 1'b1;
            bus.RegWrite = 1'b1;
            retire       = 1'b1;
            state_next   = S_FETCH;
         end
         S_MEMADR: begin
            bus.AluSrcA = 1'b1;
            bus.AluSrcB = SRCB_IMM;
            state_next  = bus.Op == OP_LW ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
            state_next  = bus.MemReady ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            bus.MemToReg = 1'b1;
            bus.RegWrite = 1'b1;
            retire       = 1'b1;
            state_next   = S_FETCH;
         end
         S_MEMWR: begin
            bus.MemWrite = 1'b1;
            bus.IorD     = 1'b1;
            retire       = bus.MemReady;
            state_next   = bus.MemReady ? S_FETCH : S_MEMWR;
         end
         S_BRANCH: begin
            bus.AluSrcA     = 1'b1;
            bus.Aop         = ALUOP_SUB;
            bus.PcWriteCond = 1'b1;
            bus.PcSrc       = PCSRC_ALUOUT;
            retire          = 1'b1;
            state_next      = S_FETCH;
         end
         S_ADDIEX: begin
            bus.AluSrcA = 1'b1;
            bus.AluSrcB = SRCB_IMM;
            state_next  = S_ADDIWB;
         end
         S_ADDIWB: begin
            bus.RegWrite = 1'b1;
            retire       = 1'b1;
            state_next   = S_FETCH;
         end
         S_JUMP: begin
            bus.PcWrite = 1'b1;
            bus.PcSrc   = PCSRC_JUMP;
            retire      = 1'b1;
            state_next  = S_FETCH;
         end
         S_ILLEGAL:
            bus.Illegal = 1'b1;
         default:
            state_next = S_RESET;
      endcase
   end

   retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .en    (retire),
      .count (bus.InstrCount)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: builds the expected per-cycle strobe trace of each instruction
// from its opcode and memory stalls, then replays it against the controller.
module tb_multicycle_control;
   import mips_pkg::*;

   typedef struct {
      logic        mr;
      logic        use_op;
      logic [17:0] exp;
      logic        ret;
   } cyc_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          vectors = 0;
   int          errors = 0;
   int          irw_cnt = 0;
   logic [31:0] exp_cnt = '0;
   logic [5:0]  cur_op = 6'b0;
   logic [17:0] obs;
   cyc_t        q[$];

   always #5 clk = ~clk;

   multicycle_control_if #(.CNT_W(32)) bus();
   multicycle_control_if #(.CNT_W(4))  bus4();

   multicycle_control #(.CNT_W(32)) dut  (.Clk(clk), .Rst_n(rst_n), .bus(bus));
   multicycle_control #(.CNT_W(4))  dut4 (.Clk(clk), .Rst_n(rst_n), .bus(bus4));

   assign bus4.Op       = OP_J;
   assign bus4.MemReady = 1'b1;
   assign bus4.Zero     = 1'b0;

   assign obs = {bus.PcWrite, bus.PcWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                 bus.IrWrite, bus.MemToReg, bus.RegDst, bus.RegWrite, bus.AluSrcA,
                 bus.AluSrcB, bus.PcSrc, bus.Aop, bus.Illegal};

   always @(posedge clk)
      if (rst_n && bus.IrWrite === 1'b1)
         irw_cnt++;

   // strobes: {PcWrite,PcWriteCond,IorD,MemRead,MemWrite,IrWrite,MemToReg,RegDst,RegWrite,AluSrcA}
   function automatic logic [17:0] mk(input logic [9:0] s, input logic [1:0] b,
                                      input logic [1:0] p, input logic [2:0] a, input logic i);
      return {s, b, p, a, i};
   endfunction

   function automatic void push(input logic mr, input logic u, input logic [17:0] e, input logic r);
      q.push_back('{mr, u, e, r});
   endfunction

   function automatic logic rnd();
      return 1'($urandom);
   endfunction

   task automatic build(input logic [5:0] op, input int fw, input int mw);
      logic [17:0] acc;
      q.delete();
      cur_op = op;
      acc = op == OP_LW ? mk(10'b0011000000, 2'b00, 2'b00, 3'b000, 1'b0)
                        : mk(10'b0010100000, 2'b00, 2'b00, 3'b000, 1'b0);
      repeat (fw) push(1'b0, 1'b0, mk(10'b0001000000, 2'b01, 2'b00, 3'b000, 1'b0), 1'b0);
      push(1'b1, 1'b0, mk(10'b1001010000, 2'b01, 2'b00, 3'b000, 1'b0), 1'b0);
      push(rnd(), 1'b1, mk(10'b0000000000, 2'b11, 2'b00, 3'b000, 1'b0), 1'b0);
      case (op)
         OP_R: begin
            push(rnd(), 1'b1, mk(10'b0000000001, 2'b00, 2'b00, 3'b001, 1'b0), 1'b0);
            push(rnd(), 1'b1, mk(10'b0000000110, 2'b00, 2'b00, 3'b000, 1'b0), 1'b1);
         end
         OP_LW, OP_SW: begin
            push(rnd(), 1'b1, mk(10'b0000000001, 2'b10, 2'b00, 3'b000, 1'b0), 1'b0);
            repeat (mw) push(1'b0, 1'b1, acc, 1'b0);
            push(1'b1, 1'b1, acc, op == OP_SW);
            if (op == OP_LW)
               push(rnd(), 1'b1, mk(10'b0000001010, 2'b00, 2'b00, 3'b000, 1'b0), 1'b1);
         end
         OP_BEQ:
            push(rnd(), 1'b1, mk(10'b0100000001, 2'b00, 2'b01, 3'b010, 1'b0), 1'b1);
         OP_ADDI: begin
            push(rnd(), 1'b1, mk(10'b0000000001, 2'b10, 2'b00, 3'b000, 1'b0), 1'b0);
            push(rnd(), 1'b1, mk(10'b0000000010, 2'b00, 2'b00, 3'b000, 1'b0), 1'b1);
         end
         OP_J:
            push(rnd(), 1'b1, mk(10'b1000000000, 2'b00, 2'b10, 3'b000, 1'b0), 1'b1);
         default:
            repeat (6) push(rnd(), 1'b1, mk(10'b0000000000, 2'b00, 2'b00, 3'b000, 1'b1), 1'b0);
      endcase
   endtask

   task automatic apply(input int n);
      for (int k = 0; k < n && k < q.size(); k++) begin
         @(negedge clk);
         bus.MemReady = q[k].mr;
         bus.Op       = q[k].use_op ? cur_op : 6'($urandom);
         bus.Zero     = rnd();
         #1;
         vectors++;
         if (obs !== q[k].exp) begin
            errors++;
            $display("FAIL strobes op=%b cycle %0d: got %b, expected %b", cur_op, k, obs, q[k].exp);
         end
         vectors++;
         if (bus.InstrCount !== exp_cnt) begin
            errors++;
            $display("FAIL instr_count op=%b cycle %0d: got %0d, expected %0d", cur_op, k, bus.InstrCount, exp_cnt);
         end
         if (q[k].ret)
            exp_cnt = exp_cnt + 32'd1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (obs !== 18'h0) begin
         errors++;
         $display("FAIL reset_async outputs: got %b, expected 0", obs);
      end
      vectors++;
      if (bus.InstrCount !== 32'd0 || bus4.InstrCount !== 4'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d/%0d, expected 0/0", bus.InstrCount, bus4.InstrCount);
      end
      exp_cnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (obs !== 18'h0) begin
         errors++;
         $display("FAIL reset_state outputs: got %b, expected 0", obs);
      end
   endtask

   task automatic test_reset();
      bus.Op = 6'b0;
      bus.MemReady = 1'b0;
      bus.Zero = 1'b0;
      do_reset();
   endtask

   task automatic test_rtype();
      build(OP_R, 0, 0);
      apply(q.size());
   endtask

   task automatic test_lw_stall();
      do_reset();
      irw_cnt = 0;
      build(OP_LW, 0, 3);
      apply(q.size());
      vectors++;
      if (irw_cnt !== 1) begin
         errors++;
         $display("FAIL lw_irwrite_pulses: got %0d, expected 1", irw_cnt);
      end
   endtask

   task automatic test_beq();
      build(OP_BEQ, 1, 0);
      apply(q.size());
      build(OP_J, 0, 0);
      apply(1);
   endtask

   task automatic test_illegal();
      do_reset();
      build(OP_J, 0, 0);
      apply(q.size());
      build(6'b111111, 0, 0);
      apply(q.size());
      do_reset();
   endtask

   task automatic test_reset_memwr();
      build(OP_ADDI, 0, 0);
      apply(q.size());
      build(OP_SW, 0, 3);
      apply(4);
      @(negedge clk);
      #1;
      vectors++;
      if (bus.MemWrite !== 1'b1 || bus.InstrCount !== 32'd1) begin
         errors++;
         $display("FAIL memwr_before_reset: MemWrite=%b count=%0d, expected 1/1", bus.MemWrite, bus.InstrCount);
      end
      do_reset();
   endtask

   task automatic test_wrap();
      do_reset();
      repeat (1 + 3 * 15) @(posedge clk);
      #1;
      vectors++;
      if (bus4.InstrCount !== 4'd15) begin
         errors++;
         $display("FAIL wrap_pre: got %0d, expected 15", bus4.InstrCount);
      end
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (bus4.InstrCount !== 4'd0) begin
         errors++;
         $display("FAIL wrap_post: got %0d, expected 0", bus4.InstrCount);
      end
   endtask

   task automatic test_random();
      logic [5:0] ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
      do_reset();
      for (int i = 0; i < 40; i++) begin
         build(ops[$urandom_range(0, 5)], int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
         apply(q.size());
      end
      @(negedge clk);
      #1;
      vectors++;
      if (bus.InstrCount !== exp_cnt) begin
         errors++;
         $display("FAIL random_final_count: got %0d, expected %0d", bus.InstrCount, exp_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_stall();
      test_beq();
      test_illegal();
      test_reset_memwr();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
